// File: rtl/reg_file_param_if.sv
// ---------------------------------------------------------------------------
// reg_file_param_if
//   Bus bundle for the parametrised register file: write port, two read
//   ports, clear-sweep request/status and the debug scanner outputs.
//
//   master : decode / testbench side (drives addresses, write data, clr_req)
//   slave  : register file side (drives rd1/rd2, busy, dbg_*)
//
//   Parameters DATA_W / ADDR_W must match the attached reg_file_param.
// ---------------------------------------------------------------------------
interface reg_file_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              we3;
   logic [ADDR_W-1:0] wa3;
   logic [DATA_W-1:0] wd3;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              clr_req;
   logic              busy;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              dbg_tick;

   modport master (
      output we3, wa3, wd3, ra1, ra2, clr_req,
      input  rd1, rd2, busy, dbg_addr, dbg_data, dbg_tick
   );

   modport slave (
      input  we3, wa3, wd3, ra1, ra2, clr_req,
      output rd1, rd2, busy, dbg_addr, dbg_data, dbg_tick
   );
endinterface

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   DEPTH = 2**ADDR_W registers of DATA_W bits. Two combinational read
//   ports, one synchronous write port, a sequenced clear sweep and a
//   free-running debug scanner for the display path.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus.we3/wa3/wd3   write enable / address / data
//   bus.ra1/ra2       read addresses,  bus.rd1/rd2 read data (combinational)
//   bus.clr_req       start a clear sweep (sampled at clk edge, IDLE only)
//   bus.busy          clear sweep in progress
//   bus.dbg_addr      register currently shown by the scanner
//   bus.dbg_data      contents of reg[dbg_addr] (combinational, never bypassed)
//   bus.dbg_tick      one-cycle pulse following each dbg_addr step
//
// Parameters: DATA_W, ADDR_W, ZERO_R0 (R0 hardwired to zero), DBG_DIV
//   (clk cycles per scanner step, >= 1).
//
// Build option: define REGFILE_BYPASS_EN to forward a qualified write to a
//   matching read port in the same cycle. Undefined keeps legacy timing
//   (new value visible only after the write edge).
// ---------------------------------------------------------------------------
module reg_file_param #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 1,
   parameter int DBG_DIV = 1
) (
   input logic             clk,
   input logic             rst,
   reg_file_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   // Keep the divider at least one bit wide so DBG_DIV=1 still elaborates.
   localparam int DIV_W = (DBG_DIV > 1) ? $clog2(DBG_DIV) : 1;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                        state;
   logic [ADDR_W-1:0]             clr_idx;
   logic                          busy_q;
   logic [DEPTH-1:0][DATA_W-1:0]  regs;
   logic                          wr_ok;

   logic [DIV_W-1:0]              div_cnt;
   logic [ADDR_W-1:0]             dbg_addr_q;
   logic                          dbg_tick_q;

   // A write only lands while idle and never onto a hardwired R0.
   assign wr_ok = bus.we3 && (state == ST_IDLE) &&
                  !((ZERO_R0 != 0) && (bus.wa3 == '0));

   // ---------------- clear-sweep FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         clr_idx <= '0;
         busy_q  <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (bus.clr_req) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
         end
      end else begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
         end
      end
   end

   // ---------------- storage ----------------
   // Sweep and write are mutually exclusive since wr_ok requires IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         regs <= '0;
      else if (state == ST_CLEAR)
         regs[clr_idx] <= '0;
      else if (wr_ok)
         regs[bus.wa3] <= bus.wd3;
   end

   function automatic logic [DATA_W-1:0] rd_store(input logic [ADDR_W-1:0] a);
      if ((ZERO_R0 != 0) && (a == '0))
         return '0;
      return regs[a];
   endfunction

`ifdef REGFILE_BYPASS_EN
   // wr_ok already excludes CLEAR and the hardwired R0 address.
   assign bus.rd1 = (wr_ok && (bus.wa3 == bus.ra1)) ? bus.wd3 : rd_store(bus.ra1);
   assign bus.rd2 = (wr_ok && (bus.wa3 == bus.ra2)) ? bus.wd3 : rd_store(bus.ra2);
`else
   assign bus.rd1 = rd_store(bus.ra1);
   assign bus.rd2 = rd_store(bus.ra2);
`endif

   // ---------------- debug scanner ----------------
   // Runs regardless of FSM state; dbg_addr wraps naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         dbg_addr_q <= '0;
         dbg_tick_q <= 1'b0;
      end else if (div_cnt == DIV_W'(DBG_DIV - 1)) begin
         div_cnt    <= '0;
         dbg_addr_q <= dbg_addr_q + 1'b1;
         dbg_tick_q <= 1'b1;
      end else begin
         div_cnt    <= div_cnt + 1'b1;
         dbg_tick_q <= 1'b0;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.dbg_addr = dbg_addr_q;
   assign bus.dbg_tick = dbg_tick_q;
   assign bus.dbg_data = rd_store(dbg_addr_q);
endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Three instances share one stimulus stream:
//     dut_z  : ZERO_R0=1, DBG_DIV=1
//     dut_nz : ZERO_R0=0, DBG_DIV=1
//     dut_d4 : ZERO_R0=1, DBG_DIV=4
//   Inputs change 1 time unit after the rising edge, outputs are sampled
//   a further unit later.
// ---------------------------------------------------------------------------
module tb_reg_file_param;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we3 = 1'b0;
   logic [2:0] wa3 = '0;
   logic [7:0] wd3 = '0;
   logic [2:0] ra1 = '0;
   logic [2:0] ra2 = '0;
   logic       clr_req = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus_z ();
   reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus_nz ();
   reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus_d4 ();

   assign bus_z.we3 = we3;   assign bus_z.wa3 = wa3;   assign bus_z.wd3 = wd3;
   assign bus_z.ra1 = ra1;   assign bus_z.ra2 = ra2;   assign bus_z.clr_req = clr_req;
   assign bus_nz.we3 = we3;  assign bus_nz.wa3 = wa3;  assign bus_nz.wd3 = wd3;
   assign bus_nz.ra1 = ra1;  assign bus_nz.ra2 = ra2;  assign bus_nz.clr_req = clr_req;
   assign bus_d4.we3 = we3;  assign bus_d4.wa3 = wa3;  assign bus_d4.wd3 = wd3;
   assign bus_d4.ra1 = ra1;  assign bus_d4.ra2 = ra2;  assign bus_d4.clr_req = clr_req;

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .DBG_DIV(1)) dut_z (
      .clk(clk), .rst(rst), .bus(bus_z.slave));
   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .DBG_DIV(1)) dut_nz (
      .clk(clk), .rst(rst), .bus(bus_nz.slave));
   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .DBG_DIV(4)) dut_d4 (
      .clk(clk), .rst(rst), .bus(bus_d4.slave));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; we3 = 1'b0; clr_req = 1'b0; ra1 = 3'd5; ra2 = 3'd6;
      step; step;
      rst = 1'b0;
      #1;
      n_chk++; if (bus_nz.rd1 !== 8'h00) $display("FAIL reset_rd1 got %h exp 00", bus_nz.rd1); else n_pass++;
      n_chk++; if (bus_nz.rd2 !== 8'h00) $display("FAIL reset_rd2 got %h exp 00", bus_nz.rd2); else n_pass++;
      n_chk++; if (bus_nz.dbg_data !== 8'h00) $display("FAIL reset_dbg_data got %h exp 00", bus_nz.dbg_data); else n_pass++;
      n_chk++; if (bus_nz.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus_nz.busy); else n_pass++;
      n_chk++; if (bus_d4.dbg_addr !== 3'd0) $display("FAIL reset_dbg_addr got %0d exp 0", bus_d4.dbg_addr); else n_pass++;
      n_chk++; if (bus_d4.dbg_tick !== 1'b0) $display("FAIL reset_dbg_tick got %b exp 0", bus_d4.dbg_tick); else n_pass++;
   endtask

   task automatic test_write_read;
      we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5; ra1 = 3'd3;
      step;
      we3 = 1'b0;
      #1;
      n_chk++; if (bus_z.rd1 !== 8'hA5) $display("FAIL wr_rd_z got %h exp a5", bus_z.rd1); else n_pass++;
      n_chk++; if (bus_nz.rd1 !== 8'hA5) $display("FAIL wr_rd_nz got %h exp a5", bus_nz.rd1); else n_pass++;
   endtask

   task automatic test_zero_r0;
      we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF; ra2 = 3'd0;
      #1;
      // R0 never forwards either, so dut_z reads zero even before the edge
      n_chk++; if (bus_z.rd2 !== 8'h00) $display("FAIL r0_pre_edge got %h exp 00", bus_z.rd2); else n_pass++;
      step;
      we3 = 1'b0;
      #1;
      n_chk++; if (bus_z.rd2 !== 8'h00) $display("FAIL r0_hardwired got %h exp 00", bus_z.rd2); else n_pass++;
      n_chk++; if (bus_nz.rd2 !== 8'hFF) $display("FAIL r0_ordinary got %h exp ff", bus_nz.rd2); else n_pass++;
   endtask

   task automatic test_bypass;
      logic [7:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 8'h3C;
`else
      exp_pre = 8'h77;
`endif
      we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h77;
      step;
      wd3 = 8'h3C; ra1 = 3'd2;
      #1;
      n_chk++; if (bus_z.rd1 !== exp_pre) $display("FAIL bypass_pre got %h exp %h", bus_z.rd1, exp_pre); else n_pass++;
      step;
      we3 = 1'b0;
      #1;
      n_chk++; if (bus_z.rd1 !== 8'h3C) $display("FAIL bypass_post got %h exp 3c", bus_z.rd1); else n_pass++;
   endtask

   task automatic test_clear;
      logic [7:0] v;
      for (int i = 0; i < 8; i++) begin
         we3 = 1'b1; wa3 = 3'(i); wd3 = 8'((i + 1) * 8'h11);
         step;
      end
      we3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); v = 8'((i + 1) * 8'h11);
         #1;
         n_chk++; if (bus_nz.rd1 !== v) $display("FAIL preload r%0d got %h exp %h", i, bus_nz.rd1, v); else n_pass++;
      end
      clr_req = 1'b1; ra2 = 3'd5;
      step;                     // edge E0 starts the sweep
      clr_req = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         if (c == 1) begin
            we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h55;
            #1;
            n_chk++; if (bus_nz.rd2 !== 8'h66) $display("FAIL clr_no_fwd got %h exp 66", bus_nz.rd2); else n_pass++;
         end
         if (c == 2) begin
            we3 = 1'b0;
            #1;
            n_chk++; if (bus_nz.rd2 !== 8'h66) $display("FAIL clr_write_dropped got %h exp 66", bus_nz.rd2); else n_pass++;
         end
         if (c == 3) begin
            ra1 = 3'd1;
            #1;
            n_chk++; if (bus_nz.rd1 !== 8'h00) $display("FAIL clr_live_cleared got %h exp 00", bus_nz.rd1); else n_pass++;
         end
         n_chk++; if (bus_nz.busy !== (c < 8)) $display("FAIL clr_busy c%0d got %b exp %b", c, bus_nz.busy, (c < 8)); else n_pass++;
         if (c < 8) step;
      end
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         #1;
         n_chk++; if (bus_nz.rd1 !== 8'h00) $display("FAIL clr_done r%0d got %h exp 00", i, bus_nz.rd1); else n_pass++;
      end
      // write and clr_req on the same idle edge: write lands, then the sweep clears it
      we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h99; clr_req = 1'b1; ra1 = 3'd6;
      step;
      we3 = 1'b0; clr_req = 1'b0;
      #1;
      n_chk++; if (bus_nz.rd1 !== 8'h99) $display("FAIL clr_wr_same_edge got %h exp 99", bus_nz.rd1); else n_pass++;
      for (int c = 0; c < 8; c++) step;
      n_chk++; if (bus_nz.rd1 !== 8'h00) $display("FAIL clr_wr_then_cleared got %h exp 00", bus_nz.rd1); else n_pass++;
      n_chk++; if (bus_nz.busy !== 1'b0) $display("FAIL clr2_busy_end got %b exp 0", bus_nz.busy); else n_pass++;
   endtask

   task automatic test_reset_mid_sweep;
      we3 = 1'b1; wa3 = 3'd7; wd3 = 8'h88;
      step;
      we3 = 1'b0; clr_req = 1'b1;
      step;                     // E0
      clr_req = 1'b0;
      step; step;               // third cycle of CLEAR
      ra1 = 3'd7;
      #1;
      n_chk++; if (bus_nz.busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", bus_nz.busy); else n_pass++;
      rst = 1'b1;
      #1;
      n_chk++; if (bus_nz.busy !== 1'b0) $display("FAIL mid_busy_async got %b exp 0", bus_nz.busy); else n_pass++;
      n_chk++; if (bus_nz.rd1 !== 8'h00) $display("FAIL mid_r7_cleared got %h exp 00", bus_nz.rd1); else n_pass++;
      n_chk++; if (bus_z.dbg_addr !== 3'd0) $display("FAIL mid_dbg_addr got %0d exp 0", bus_z.dbg_addr); else n_pass++;
      n_chk++; if (bus_d4.dbg_tick !== 1'b0) $display("FAIL mid_dbg_tick got %b exp 0", bus_d4.dbg_tick); else n_pass++;
      step;
      rst = 1'b0;
      we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h44; ra1 = 3'd4;
      step;
      we3 = 1'b0;
      #1;
      n_chk++; if (bus_nz.rd1 !== 8'h44) $display("FAIL mid_idle_write got %h exp 44", bus_nz.rd1); else n_pass++;
      n_chk++; if (bus_nz.busy !== 1'b0) $display("FAIL mid_busy_after got %b exp 0", bus_nz.busy); else n_pass++;
   endtask

   task automatic test_dbg_scan;
      logic [2:0] ea;
      logic [7:0] ed;
      rst = 1'b1;
      step;
      rst = 1'b0;
      we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5;
      #1;
      n_chk++; if (bus_d4.dbg_addr !== 3'd0) $display("FAIL scan_start_addr got %0d exp 0", bus_d4.dbg_addr); else n_pass++;
      for (int k = 1; k <= 36; k++) begin
         step;
         if (k == 1) we3 = 1'b0;
         #1;
         ea = 3'((k / 4) % 8);
         ed = (ea == 3'd3) ? 8'hA5 : 8'h00;
         n_chk++; if (bus_d4.dbg_addr !== ea) $display("FAIL scan4_addr k%0d got %0d exp %0d", k, bus_d4.dbg_addr, ea); else n_pass++;
         n_chk++; if (bus_d4.dbg_tick !== (k % 4 == 0)) $display("FAIL scan4_tick k%0d got %b exp %b", k, bus_d4.dbg_tick, (k % 4 == 0)); else n_pass++;
         n_chk++; if (bus_d4.dbg_data !== ed) $display("FAIL scan4_data k%0d got %h exp %h", k, bus_d4.dbg_data, ed); else n_pass++;
         ea = 3'(k % 8);
         ed = (ea == 3'd3) ? 8'hA5 : 8'h00;
         n_chk++; if (bus_z.dbg_addr !== ea) $display("FAIL scan1_addr k%0d got %0d exp %0d", k, bus_z.dbg_addr, ea); else n_pass++;
         n_chk++; if (bus_z.dbg_tick !== 1'b1) $display("FAIL scan1_tick k%0d got %b exp 1", k, bus_z.dbg_tick); else n_pass++;
         n_chk++; if (bus_z.dbg_data !== ed) $display("FAIL scan1_data k%0d got %h exp %h", k, bus_z.dbg_data, ed); else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_zero_r0;
      test_bypass;
      test_clear;
      test_reset_mid_sweep;
      test_dbg_scan;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 8x8 datapath register file: 2 async read ports, 1 sync write port, width/depth set by parameters.
- Adds async reset, optional hardwired-zero R0, and a sequenced clear engine that zeroes every register on request.
- Adds a free-running debug scanner that walks all registers for the LCD/HEX display path, so display width is not tied to register count.
- Sits between instruction decode (ra1/ra2/wa3) and the ULA/writeback mux of the single-cycle CPU.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes; 0 = R0 is an ordinary register.
- DBG_DIV, 1, clk cycles per debug scanner step; legal range >=1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we3  in  1  write enable
- wa3  in  ADDR_W  write address
- wd3  in  DATA_W  write data
- ra1  in  ADDR_W  read address port 1
- ra2  in  ADDR_W  read address port 2
- rd1  out  DATA_W  read data port 1, combinational
- rd2  out  DATA_W  read data port 2, combinational
- clr_req  in  1  start clear sweep, sampled at clk edge
- busy  out  1  clear sweep in progress
- dbg_addr  out  ADDR_W  register currently shown by scanner
- dbg_data  out  DATA_W  contents of reg[dbg_addr], combinational
- dbg_tick  out  1  one-cycle pulse when dbg_addr advances

Behaviour:
- Reset (rst=1, async): all registers 0, FSM=IDLE, busy=0, clear index 0, divider 0, dbg_addr=0, dbg_tick=0. rd1/rd2/dbg_data therefore read 0.
- Reset asserted mid-sweep aborts the sweep. State after release is identical to a normal reset.
- Read: rdN = reg[raN], purely combinational, 0-cycle latency.
- If ZERO_R0=1 and raN=0, rdN=0 regardless of storage. dbg_data follows the same rule.
- Write qualifies when we3=1, FSM=IDLE, and !(ZERO_R0 && wa3==0). A qualified write updates reg[wa3] at the rising edge.
- Write visibility: a new value appears on rdN after the edge, except as given under Optional Feature.
- FSM states:
  - IDLE: clr_req=1 at an edge -> CLEAR, clear index=0, busy=1 from the next cycle.
  - CLEAR: each edge writes 0 to reg[index] and increments index. The edge that writes index DEPTH-1 -> IDLE, busy=0. The sweep takes exactly DEPTH cycles.
- During CLEAR:
  - we3 is ignored; writes are dropped, not queued.
  - clr_req is ignored.
  - Reads return live storage: already-cleared entries read 0, uncleared entries keep their old value.
- clr_req and we3 both high at the same IDLE edge: the write completes at that edge, the sweep starts next cycle and clears it.
- clr_req held high: when the sweep ends, IDLE samples it again and starts a new sweep.
- Debug scanner (runs in all FSM states):
  - The divider counts 0..DBG_DIV-1.
  - At the edge where the divider equals DBG_DIV-1, the divider returns to 0, dbg_addr increments (DEPTH-1 wraps to 0), and dbg_tick=1 for the following cycle.
  - DBG_DIV=1 steps every cycle, and dbg_tick stays 1 continuously.
- Width rules: wd3 is stored unmodified, with no sign extension. Addresses wrap modulo DEPTH by construction.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When a qualified write has wa3==raN, rdN=wd3 combinationally in the same cycle. Never active during CLEAR or for the ZERO_R0 address. dbg_data is not bypassed.
- Undefined: rdN shows the old contents until after the write edge (legacy single-cycle timing).

Test Plan:
- Reset, then rst released: rd1=rd2=dbg_data=0x00, busy=0, dbg_addr=0. Then we3=1, wa3=3, wd3=0xA5, one edge; ra1=3 -> rd1=0xA5.
- ZERO_R0=1: we3=1, wa3=0, wd3=0xFF, edge; ra2=0 -> rd2=0x00. Same stimulus with ZERO_R0=0 -> rd2=0xFF.
- Clear sweep:
  - Preload all 8 registers with 0x11..0x88.
  - Pulse clr_req: busy=1 for exactly 8 cycles.
  - Write of 0x55 to reg 5 during the sweep is dropped.
  - After busy falls, every register reads 0x00.
- rst pulsed at the 3rd cycle of CLEAR: busy=0 immediately, all registers 0, dbg_addr=0.
- DBG_DIV=4 after reset: dbg_addr goes 0,1,2,...,7,0 every 4 cycles; dbg_tick pulses exactly once per step; dbg_data tracks register contents (e.g. 0xA5 when dbg_addr=3).
- Bypass, same cycle, with we3=1, wa3=2, wd3=0x3C, ra1=2:
  - REGFILE_BYPASS_EN defined: rd1=0x3C before the edge.
  - Undefined: rd1 holds the old value until the edge, then 0x3C.
